isqrt_rr_scheduler: RTL and testbench

ISQRT_RR_SCHEDULER -- requirements
Module: isqrt_rr_scheduler

---
 rtl/isqrt_rr_scheduler_pkg.sv | 12 +
 rtl/isqrt_rr_scheduler_if.sv | 25 ++
 rtl/isqrt_rr_scheduler_fifo.sv | 51 +++++
 rtl/isqrt_rr_scheduler.sv | 90 +++++++++
 tb/tb_isqrt_rr_scheduler.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/isqrt_rr_scheduler_pkg.sv
// Shared constants and tag-width helper for the isqrt round-robin scheduler.
// Exports N_REQ_DEF, N_PIPE_DEF and tag_w().
package isqrt_sched_pkg;

  localparam int N_REQ_DEF  = 3;
  localparam int N_PIPE_DEF = 16;

  function automatic int tag_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/isqrt_rr_scheduler_if.sv
// Requester-side bundle: per-requester argument handshake and result pulse.
// slave = scheduler side, master = requester side.
interface isqrt_rr_scheduler_if
  import isqrt_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
);

  logic [N_REQ-1:0]       req_vld;
  logic [N_REQ-1:0][31:0] req_x;
  logic [N_REQ-1:0]       req_rdy;
  logic [N_REQ-1:0]       rsp_vld;
  logic [15:0]            rsp_y;

  modport slave (
    input  req_vld, req_x,
    output req_rdy, rsp_vld, rsp_y
  );

  modport master (
    output req_vld, req_x,
    input  req_rdy, rsp_vld, rsp_y
  );

endinterface

// File: rtl/isqrt_rr_scheduler_fifo.sv
// In-order flip-flop FIFO with occupancy counter (any DEPTH >= 1).
// Ports: clk, rst (async low), push/din, pop/dout, empty, count.
module flip_flop_fifo_with_counter #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 18,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/isqrt_rr_scheduler.sv
// Round-robin arbiter sharing one fixed-latency pipelined isqrt among N_REQ.
// Ports: clk, rst, en, rq (requester bundle), iq_* (isqrt side), busy, err.
module isqrt_rr_scheduler
  import isqrt_sched_pkg::*;
#(
  parameter int N_REQ         = N_REQ_DEF,
  parameter int N_PIPE_STAGES = N_PIPE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  isqrt_rr_scheduler_if.slave  rq,
  output logic                 iq_x_vld,
  output logic [31:0]          iq_x,
  input  logic                 iq_y_vld,
  input  logic [15:0]          iq_y,
  output logic                 busy,
  output logic                 err
);

  localparam int TW    = tag_w(N_REQ);
  localparam int DEPTH = N_PIPE_STAGES + 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic [TW-1:0] ptr;
  logic [TW-1:0] k;
  logic [TW-1:0] gnt_idx;
  logic          hs;
  logic [TW-1:0] head;
  logic          empty;
  logic          pop;
  logic [CW-1:0] cnt;

  // Walk from ptr upward with wrap; first valid wins.
  always_comb begin
    k       = ptr;
    hs      = 1'b0;
    gnt_idx = '0;
    if (rst && en) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!hs && rq.req_vld[k]) begin
          hs      = 1'b1;
          gnt_idx = k;
        end
        k = (k == TW'(N_REQ - 1)) ? '0 : k + 1'b1;
      end
    end
    rq.req_rdy = hs ? (N_REQ'(1) << gnt_idx) : '0;
  end

  assign pop  = iq_y_vld & ~empty;
  assign busy = (cnt != '0);

  flip_flop_fifo_with_counter #(
    .WIDTH (TW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (hs),
    .din   (gnt_idx),
    .pop   (pop),
    .dout  (head),
    .empty (empty),
    .count (cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr        <= '0;
      iq_x_vld   <= 1'b0;
      iq_x       <= '0;
      rq.rsp_vld <= '0;
      rq.rsp_y   <= '0;
      err        <= 1'b0;
    end else begin
      iq_x_vld <= hs;
      if (hs) begin
        iq_x <= rq.req_x[gnt_idx];
        ptr  <= (gnt_idx == TW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
      rq.rsp_vld <= pop ? (N_REQ'(1) << head) : '0;
      if (pop) rq.rsp_y <= iq_y;
      // A result with no owner means the pipe and tag queue disagree.
      if (iq_y_vld && empty) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_isqrt_rr_scheduler.sv
// Bench for isqrt_rr_scheduler: isqrt pipe model plus transaction scoreboard.
// Directed phases with randomized arguments; per-cycle assertions.
module tb_isqrt_rr_scheduler;
  import isqrt_sched_pkg::*;

  localparam int N = 3;
  localparam int L = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b1;
  logic        iq_x_vld;
  logic [31:0] iq_x;
  logic        iq_y_vld;
  logic [15:0] iq_y;
  logic        busy;
  logic        err;
  logic        inject = 1'b0;

  always #5 clk = ~clk;

  isqrt_rr_scheduler_if #(.N_REQ(N)) rq ();

  isqrt_rr_scheduler #(
    .N_REQ         (N),
    .N_PIPE_STAGES (L)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .rq       (rq.slave),
    .iq_x_vld (iq_x_vld),
    .iq_x     (iq_x),
    .iq_y_vld (iq_y_vld),
    .iq_y     (iq_y),
    .busy     (busy),
    .err      (err)
  );

  function automatic logic [15:0] isqrt32(input logic [31:0] x);
    logic [15:0] y;
    y = '0;
    for (int b = 15; b >= 0; b--) begin
      logic [15:0] c;
      c = y | (16'd1 << b);
      if ({32'd0, c} * {32'd0, c} <= {32'd0, x}) y = c;
    end
    return y;
  endfunction

  // External isqrt: fixed L-cycle pipe, not reset.
  logic        pv [L] = '{default: 1'b0};
  logic [15:0] py [L] = '{default: 16'd0};

  always @(posedge clk) begin
    pv[0] <= iq_x_vld;
    py[0] <= isqrt32(iq_x);
    for (int i = 1; i < L; i++) begin
      pv[i] <= pv[i-1];
      py[i] <= py[i-1];
    end
  end

  assign iq_y_vld = pv[L-1] | inject;
  assign iq_y     = inject ? 16'h5a5a : py[L-1];

  typedef struct {
    int          t;
    int          k;
    logic [15:0] y;
  } ent_t;

  ent_t        q[$];
  int          stray[$];
  int          cyc    = 0;
  int          mptr   = 0;
  logic        merr   = 1'b0;
  logic        mxv    = 1'b0;
  logic [31:0] mx     = '0;
  logic [15:0] my     = '0;
  bit          in_rst = 1'b0;
  logic [N-1:0] act   = '0;
  logic [N-1:0] one   = '0;
  bit          rndx   = 1'b0;
  int          tests  = 0;
  int          fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++)
      if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic set_act(input logic [N-1:0] m);
    act        = m;
    rq.req_vld = m;
  endtask

  task automatic cycle();
    int          g;
    logic [N-1:0] erdy;
    logic [N-1:0] ervld;
    bit          eb;
    @(negedge clk);
    if (!rst) begin
      if (!in_rst)
        foreach (q[i])
          if (q[i].t <= cyc - 2) stray.push_back(q[i].t + 1 + L);
      q.delete();
      mptr = 0;
      merr = 1'b0;
      mxv  = 1'b0;
      mx   = '0;
      my   = '0;
    end
    g     = (rst && en) ? pick(rq.req_vld, mptr) : -1;
    erdy  = (g >= 0) ? (N'(1) << g) : '0;
    ervld = '0;
    eb    = 1'b0;
    if (q.size() > 0 && q[0].t + 2 + L == cyc) begin
      ervld = N'(1) << q[0].k;
      my    = q[0].y;
    end
    foreach (q[i])
      if (cyc >= q[i].t + 1 && cyc <= q[i].t + 1 + L) eb = 1'b1;
    chk("req_rdy", rq.req_rdy, erdy);
    chk("rsp_vld", rq.rsp_vld, ervld);
    chk("rsp_y", rq.rsp_y, my);
    chk("busy", busy, eb);
    chk("err", err, merr);
    chk("iq_x_vld", iq_x_vld, mxv);
    chk("iq_x", iq_x, mx);
    if (ervld != '0) void'(q.pop_front());
    mxv = rst && (g >= 0);
    if (g >= 0) begin
      mx = rq.req_x[g];
      q.push_back('{cyc, g, isqrt32(rq.req_x[g])});
      mptr = (g + 1) % N;
    end
    if (rst) begin
      if (inject && !eb) merr = 1'b1;
      foreach (stray[i])
        if (stray[i] == cyc) merr = 1'b1;
    end
    in_rst = !rst;
    @(posedge clk);
    #1;
    cyc++;
    inject = 1'b0;
    if (g >= 0) begin
      if (one[g]) act[g] = 1'b0;
      if (rndx) rq.req_x[g] = $urandom;
    end
    rq.req_vld = act;
  endtask

  initial begin
    rq.req_vld = '0;
    rq.req_x   = '0;
    #1;
    rst = 1'b0;
    set_act('1);
    repeat (3) cycle();
    set_act('0);
    rst = 1'b1;
    repeat (2) cycle();

    // single request
    one = '1;
    rq.req_x[0] = 32'd144;
    set_act(3'b001);
    repeat (L + 4) cycle();
    chk("single_y", rq.rsp_y, 32'd12);

    // contention, fixed arguments
    one = '0;
    rq.req_x[0] = 32'd16;
    rq.req_x[1] = 32'd49;
    rq.req_x[2] = 32'd100;
    set_act(3'b111);
    repeat (9) cycle();
    set_act('0);
    repeat (L + 3) cycle();

    // fairness between 0 and 2
    rndx = 1'b1;
    for (int i = 0; i < N; i++) rq.req_x[i] = $urandom;
    set_act(3'b101);
    repeat (12) cycle();
    set_act('0);
    repeat (L + 3) cycle();

    // en toggle mid-stream
    set_act(3'b111);
    repeat (5) cycle();
    en = 1'b0;
    repeat (5) cycle();
    en = 1'b1;
    repeat (6) cycle();
    set_act('0);
    repeat (L + 3) cycle();

    // random masks and enable
    repeat (40) begin
      set_act(N'($urandom));
      en = ($urandom_range(0, 7) != 0);
      cycle();
    end
    en = 1'b1;
    set_act('0);
    repeat (L + 3) cycle();

    // spurious result
    inject = 1'b1;
    cycle();
    repeat (3) cycle();
    chk("err_sticky", err, 32'd1);

    // reset with results in flight
    set_act(3'b111);
    repeat (5) cycle();
    set_act('0);
    repeat (2) cycle();
    rst = 1'b0;
    repeat (2) cycle();
    rst = 1'b1;
    repeat (L + 2) cycle();
    chk("err_stray", err, 32'd1);

    // fresh request after reset
    one = '1;
    rq.req_x[1] = $urandom;
    set_act(3'b010);
    repeat (L + 4) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
